// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: operands are registered at acceptance, then each stage
// resolves GROUPS_PER_STAGE 4-bit lookahead groups from the carry registered by the previous stage.
module cla_pipe_adder #(
   parameter int WIDTH            = 16,
   parameter int GROUPS_PER_STAGE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);
   localparam int GPS      = GROUPS_PER_STAGE;
   localparam int SW       = 4 * GPS;
   localparam int N_STAGES = WIDTH / SW;

   // Level k holds an operation that has had k stages resolved; level N_STAGES is the output.
   logic             valid_reg [0:N_STAGES];
   logic             c_reg     [0:N_STAGES];
   logic [WIDTH-1:0] a_reg     [0:N_STAGES-1];
   logic [WIDTH-1:0] b_reg     [0:N_STAGES-1];
   logic [WIDTH-1:0] sum_reg   [1:N_STAGES];
   logic             ovf_reg;

   logic [WIDTH-1:0] sum_next  [0:N_STAGES-1];
   logic             c_next    [0:N_STAGES-1];
   logic             ovf_next;
   logic             advance;

   assign advance   = !valid_reg[N_STAGES] || out_ready;
   assign in_ready  = advance;
   assign out_valid = valid_reg[N_STAGES];
   assign out_sum   = sum_reg[N_STAGES];
   assign out_cout  = c_reg[N_STAGES];
   assign out_ovf   = ovf_reg;

   for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
      logic [SW-1:0]    sa, sb, sp, sg, bc, ssum;
      logic [GPS-1:0]   grp_p, grp_g;
      logic [GPS:0]     gc;
      logic [WIDTH-1:0] snext;
      logic             term;

      assign sa = a_reg[gi][gi*SW +: SW];
      assign sb = b_reg[gi][gi*SW +: SW];
      assign sp = sa ^ sb;
      assign sg = sa & sb;

      for (genvar gj = 0; gj < GPS; gj++) begin : g_grp
         localparam int B = 4 * gj;
         assign grp_p[gj] = &sp[B +: 4];
         assign grp_g[gj] = sg[B+3] | (sp[B+3] & sg[B+2]) | (sp[B+3] & sp[B+2] & sg[B+1])
                          | (sp[B+3] & sp[B+2] & sp[B+1] & sg[B]);
         assign bc[B]     = gc[gj];
         assign bc[B+1]   = sg[B] | (sp[B] & gc[gj]);
         assign bc[B+2]   = sg[B+1] | (sp[B+1] & sg[B]) | (sp[B+1] & sp[B] & gc[gj]);
         assign bc[B+3]   = sg[B+2] | (sp[B+2] & sg[B+1]) | (sp[B+2] & sp[B+1] & sg[B])
                          | (sp[B+2] & sp[B+1] & sp[B] & gc[gj]);
      end

      // Second lookahead level: each group carry is a flat sum of products over group P/G.
      always_comb begin
         gc    = '0;
         term  = 1'b0;
         gc[0] = c_reg[gi];
         for (int j = 1; j <= GPS; j++) begin
            term = c_reg[gi];
            for (int l = 0; l < j; l++) term = term & grp_p[l];
            gc[j] = term;
            for (int m = 0; m < j; m++) begin
               term = grp_g[m];
               for (int l = m + 1; l < j; l++) term = term & grp_p[l];
               gc[j] = gc[j] | term;
            end
         end
      end

      assign ssum = sp ^ bc;

      if (gi == 0) begin : g_first
         always_comb begin
            snext         = '0;
            snext[0 +: SW] = ssum;
         end
      end else begin : g_rest
         always_comb begin
            snext               = sum_reg[gi];
            snext[gi*SW +: SW]  = ssum;
         end
      end

      assign sum_next[gi] = snext;
      assign c_next[gi]   = gc[GPS];

      if (gi == N_STAGES - 1) begin : g_last
         assign ovf_next = bc[SW-1] ^ gc[GPS];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= N_STAGES; k++) begin
            valid_reg[k] <= 1'b0;
            c_reg[k]     <= 1'b0;
         end
         for (int k = 0; k < N_STAGES; k++) begin
            a_reg[k] <= '0;
            b_reg[k] <= '0;
         end
         for (int k = 1; k <= N_STAGES; k++) sum_reg[k] <= '0;
         ovf_reg <= 1'b0;
      end else if (advance) begin
         valid_reg[0] <= in_valid;
         a_reg[0]     <= in_a;
         b_reg[0]     <= in_b ^ {WIDTH{in_sub}};
         c_reg[0]     <= in_cin ^ in_sub;
         for (int k = 0; k < N_STAGES; k++) begin
            valid_reg[k+1] <= valid_reg[k];
            sum_reg[k+1]   <= sum_next[k];
            c_reg[k+1]     <= c_next[k];
         end
         for (int k = 1; k < N_STAGES; k++) begin
            a_reg[k] <= a_reg[k-1];
            b_reg[k] <= b_reg[k-1];
         end
         ovf_reg <= ovf_next;
      end
   end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases, backpressure and async reset on 16/1, random sweeps on 32/2 and 8/1.
module tb_cla_pipe_adder;
   logic clk = 1'b0;
   logic rst;
   logic        ivs [3];
   logic        ors [3];
   logic        cins[3];
   logic        subs[3];
   logic [31:0] as  [3];
   logic [31:0] bs  [3];
   logic        ir  [3];
   logic        ov  [3];
   logic        oc  [3];
   logic        oo  [3];
   logic [15:0] sum0;
   logic [31:0] sum1;
   logic [7:0]  sum2;
   logic [31:0] osum[3];

   int checks = 0;
   int errors = 0;
   int wid[3] = '{16, 32, 8};
   logic [33:0] expq[$];
   int consumed;
   int sent;
   bit held;
   logic [31:0] h_sum;
   logic h_c, h_o;

   always #5 clk = ~clk;

   assign osum[0] = {16'h0, sum0};
   assign osum[1] = sum1;
   assign osum[2] = {24'h0, sum2};

   cla_pipe_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(ivs[0]), .in_ready(ir[0]), .in_a(as[0][15:0]), .in_b(bs[0][15:0]),
      .in_cin(cins[0]), .in_sub(subs[0]), .out_valid(ov[0]), .out_ready(ors[0]), .out_sum(sum0),
      .out_cout(oc[0]), .out_ovf(oo[0]));
   cla_pipe_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(ivs[1]), .in_ready(ir[1]), .in_a(as[1]), .in_b(bs[1]),
      .in_cin(cins[1]), .in_sub(subs[1]), .out_valid(ov[1]), .out_ready(ors[1]), .out_sum(sum1),
      .out_cout(oc[1]), .out_ovf(oo[1]));
   cla_pipe_adder #(.WIDTH(8), .GROUPS_PER_STAGE(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(ivs[2]), .in_ready(ir[2]), .in_a(as[2][7:0]), .in_b(bs[2][7:0]),
      .in_cin(cins[2]), .in_sub(subs[2]), .out_valid(ov[2]), .out_ready(ors[2]), .out_sum(sum2),
      .out_cout(oc[2]), .out_ovf(oo[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed interpretations of the operands.
   function automatic logic [31:0] ref_op(input int w, input longint a, input longint b, input bit cin,
                                          input bit sub, output bit cout, output bit ovf);
      longint full, half, sa, sb, u, s;
      full = longint'(1) << w;
      half = full >> 1;
      sa   = (a >= half) ? a - full : a;
      sb   = (b >= half) ? b - full : b;
      if (!sub) begin
         u    = a + b + longint'(cin);
         s    = sa + sb + longint'(cin);
         cout = (u >= full);
      end else begin
         u    = a - b - longint'(cin);
         s    = sa - sb - longint'(cin);
         cout = (u >= 0);
      end
      ovf = (s >= half) || (s < -half);
      return 32'(u & (full - 1));
   endfunction

   // One cycle: called at a negedge, drives inputs, samples #1 later, returns at the next negedge.
   task automatic step(input int idx, input bit iv, input logic [31:0] a, input logic [31:0] b,
                       input bit cin, input bit sub, input bit ordy, output bit acc);
      logic [31:0] m;
      logic [33:0] e;
      logic [31:0] es;
      bit ec, eo;
      m = (wid[idx] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[idx]) - 32'd1);
      ivs[idx] = iv; as[idx] = a & m; bs[idx] = b & m; cins[idx] = cin; subs[idx] = sub; ors[idx] = ordy;
      acc = 1'b0;
      #1;
      if (ordy) chk("in_ready open", 64'(ir[idx]), 64'd1);
      else if (ov[idx]) chk("in_ready stalled", 64'(ir[idx]), 64'd0);
      if (held) begin
         chk("stall sum", 64'(osum[idx]), 64'(h_sum));
         chk("stall cout", 64'(oc[idx]), 64'(h_c));
         chk("stall ovf", 64'(oo[idx]), 64'(h_o));
         held = 1'b0;
      end
      if (ov[idx] && ordy) begin
         if (expq.size() == 0) begin
            chk("unexpected result", 64'(ov[idx]), 64'd0);
         end else begin
            e = expq.pop_front();
            chk("sum", 64'(osum[idx]), 64'(e[31:0]));
            chk("cout", 64'(oc[idx]), 64'(e[32]));
            chk("ovf", 64'(oo[idx]), 64'(e[33]));
         end
         consumed++;
         $display("inst%0d result sum=%h cout=%b ovf=%b", idx, osum[idx], oc[idx], oo[idx]);
      end else if (ov[idx] && !ordy) begin
         held = 1'b1; h_sum = osum[idx]; h_c = oc[idx]; h_o = oo[idx];
      end
      if (iv && ir[idx]) begin
         es = ref_op(wid[idx], longint'(a & m), longint'(b & m), cin, sub, ec, eo);
         expq.push_back({eo, ec, es});
         acc = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic single_op(input string tag, input logic [15:0] a, input logic [15:0] b, input bit cin,
                            input bit sub, input logic [15:0] es, input bit ec, input bit eo);
      ivs[0] = 1'b1; as[0] = {16'h0, a}; bs[0] = {16'h0, b}; cins[0] = cin; subs[0] = sub; ors[0] = 1'b1;
      @(negedge clk);
      ivs[0] = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         chk({tag, " valid"}, 64'(ov[0]), 64'(c == 4));
         if (c == 4) begin
            chk({tag, " sum"}, 64'(osum[0]), 64'(es));
            chk({tag, " cout"}, 64'(oc[0]), 64'(ec));
            chk({tag, " ovf"}, 64'(oo[0]), 64'(eo));
            $display("inst0 %s sum=%h cout=%b ovf=%b", tag, osum[0], oc[0], oo[0]);
         end
      end
   endtask

   task automatic sweep(input int idx, input int nops);
      bit acc;
      int cyc;
      sent = 0; consumed = 0; cyc = 0; held = 1'b0;
      expq.delete();
      while (consumed < nops && cyc < 20000) begin
         step(idx, (sent < nops) && ($urandom_range(0, 3) != 0), $urandom, $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
         if (acc) sent++;
         cyc++;
      end
      for (int n = 0; n < 10; n++) step(idx, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
      chk("sweep consumed", 64'(consumed), 64'(nops));
      chk("sweep leftover", 64'(expq.size()), 64'd0);
   endtask

   initial begin
      bit acc;
      for (int i = 0; i < 3; i++) begin
         ivs[i] = 1'b0; ors[i] = 1'b1; cins[i] = 1'b0; subs[i] = 1'b0; as[i] = '0; bs[i] = '0;
      end
      held = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("reset valid", 64'(ov[0]), 64'd0);
      chk("reset sum", 64'(osum[0]), 64'd0);
      chk("reset cout", 64'(oc[0]), 64'd0);
      chk("reset ovf", 64'(oo[0]), 64'd0);
      chk("reset in_ready", 64'(ir[0]), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      single_op("00FF+0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      single_op("FFFF+0000+1", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      single_op("7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      single_op("8000-0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      single_op("0003-0005", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      // Backpressure: 8 ops streamed, downstream stalls for 3 cycles mid-stream.
      sent = 0; consumed = 0; expq.delete();
      for (int n = 0; n < 20; n++) begin
         step(0, sent < 8, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              !(n >= 6 && n < 9), acc);
         if (acc) sent++;
      end
      chk("bp consumed", 64'(consumed), 64'd8);
      chk("bp leftover", 64'(expq.size()), 64'd0);

      // Async reset with 3 ops in flight and the first one held at the output.
      sent = 0; consumed = 0; expq.delete();
      for (int n = 0; n < 6; n++) begin
         step(0, sent < 3, 32'h1234 + 32'(n), 32'h0101, 1'b0, 1'b0, 1'b0, acc);
         if (acc) sent++;
      end
      chk("pre-reset valid", 64'(ov[0]), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("async rst valid", 64'(ov[0]), 64'd0);
      chk("async rst sum", 64'(osum[0]), 64'd0);
      chk("async rst cout", 64'(oc[0]), 64'd0);
      chk("async rst ovf", 64'(oo[0]), 64'd0);
      chk("async rst in_ready", 64'(ir[0]), 64'd1);
      expq.delete(); held = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      consumed = 0;
      step(0, 1'b1, 32'h0000_4321, 32'h0000_1111, 1'b1, 1'b1, 1'b1, acc);
      for (int n = 0; n < 10; n++) step(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
      chk("post-reset consumed", 64'(consumed), 64'd1);
      chk("post-reset leftover", 64'(expq.size()), 64'd0);

      sweep(1, 1000);
      sweep(2, 1000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
